// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD command sequencer: FSM states,
// controller opcodes and program-word field layout.
package lcd_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      WAIT_Q,
      DECODE,
      WAIT_RDY,
      ISSUE,
      WAIT_ACK,
      WAIT_CMPL,
      FINISH
   } state_t;

   localparam logic [2:0] OP_WRITE = 3'd0;
   localparam logic [2:0] OP_UP    = 3'd1;
   localparam logic [2:0] OP_DOWN  = 3'd2;
   localparam logic [2:0] OP_LEFT  = 3'd3;
   localparam logic [2:0] OP_RIGHT = 3'd4;
   localparam logic [2:0] OP_AVG   = 3'd5;
   localparam logic [2:0] OP_MIRX  = 3'd6;
   localparam logic [2:0] OP_MIRY  = 3'd7;

   localparam int END_B   = 7;
   localparam int REP_MSB = 6;
   localparam int REP_LSB = 3;
   localparam int OP_MSB  = 2;

   // END with REP=0 and OP=write carries no command, it only stops the program
   function automatic logic is_terminator(input logic [7:0] word);
      return word[END_B] && (word[REP_MSB:REP_LSB] == 4'd0) && (word[OP_MSB:0] == OP_WRITE);
   endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Program ROM read port plus LCD controller command handshake, as seen
// from the sequencer (master) and from the ROM/controller side (slave).
interface lcd_cmd_sequencer_if #(
   parameter int PROG_AW = 5
);
   logic               prog_en;
   logic [PROG_AW-1:0] prog_a;
   logic [7:0]         prog_q;
   logic [2:0]         cmd;
   logic               cmd_valid;
   logic               lcd_busy;
   logic               lcd_done;

   modport master (
      output prog_en, prog_a, cmd, cmd_valid,
      input  prog_q, lcd_busy, lcd_done
   );

   modport slave (
      input  prog_en, prog_a, cmd, cmd_valid,
      output prog_q, lcd_busy, lcd_done
   );
endinterface

// File: rtl/lcd_seq_wdog.sv
// Wait-state watchdog: counts cycles in the current wait state, the count
// includes the present cycle so expired fires on the (2^TMO_W-1)-th cycle.
module lcd_seq_wdog #(
   parameter int TMO_W = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TMO_W-1:0] CNT_MAX = '1;

   logic [TMO_W-1:0] cnt_q;
   logic [TMO_W-1:0] cnt_cur;

   always_comb begin
      cnt_cur = cnt_q;
      if (clr) begin
         cnt_cur = TMO_W'(1);
      end else if (cnt_q != CNT_MAX) begin
         cnt_cur = cnt_q + TMO_W'(1);
      end
   end

   assign expired = en && (cnt_cur == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_cur;
      end else begin
         cnt_q <= '0;
      end
   end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Autonomous command master for the LCD image controller: fetches a program
// from ROM, expands repeat counts and issues commands over the busy handshake.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | ROM read enable for one cycle
// WAIT_Q    | capture ROM word
// DECODE    | load opcode/repeat, detect terminator
// WAIT_RDY  | wait for controller not busy
// ISSUE     | one-cycle cmd_valid strobe
// WAIT_ACK  | wait for controller to raise busy
// WAIT_CMPL | wait for busy to drop (or done after a write)
// FINISH    | report completion, back to IDLE
module lcd_cmd_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int PROG_AW = 5,
   parameter int TMO_W   = 8,
   parameter int CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   lcd_cmd_sequencer_if.master   bus,
   output logic                  seq_busy,
   output logic                  seq_done,
   output logic                  err,
   output logic [CNT_W-1:0]      issued_cnt
);

   localparam logic [CNT_W-1:0]   ISSUED_MAX = '1;
   localparam logic [PROG_AW-1:0] PA_LAST    = '1;

   state_t             state;
   state_t             state_prev;
   logic               prog_en_r;
   logic [PROG_AW-1:0] prog_a_r;
   logic [7:0]         word_r;
   logic [3:0]         rep_cnt;
   logic [2:0]         cmd_r;
   logic               cmd_valid_r;
   logic               end_r;
   logic               wr_mode;
   logic               in_wait;
   logic               wd_clr;
   logic               wd_exp;

   assign bus.prog_en   = prog_en_r;
   assign bus.prog_a    = prog_a_r;
   assign bus.cmd       = cmd_r;
   assign bus.cmd_valid = cmd_valid_r;

   assign in_wait = (state == WAIT_RDY) || (state == WAIT_ACK) || (state == WAIT_CMPL);
   assign wd_clr  = (state != state_prev);

   lcd_seq_wdog #(.TMO_W(TMO_W)) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (wd_clr),
      .en      (in_wait),
      .expired (wd_exp)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         state_prev  <= IDLE;
         prog_en_r   <= 1'b0;
         prog_a_r    <= '0;
         word_r      <= '0;
         rep_cnt     <= '0;
         cmd_r       <= '0;
         cmd_valid_r <= 1'b0;
         end_r       <= 1'b0;
         wr_mode     <= 1'b0;
         seq_busy    <= 1'b0;
         seq_done    <= 1'b0;
         err         <= 1'b0;
         issued_cnt  <= '0;
      end else begin
         state_prev <= state;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= FETCH;
                  prog_en_r  <= 1'b1;
                  prog_a_r   <= '0;
                  seq_busy   <= 1'b1;
                  seq_done   <= 1'b0;
                  err        <= 1'b0;
                  issued_cnt <= '0;
               end
            end
            FETCH: begin
               prog_en_r <= 1'b0;
               state     <= WAIT_Q;
            end
            WAIT_Q: begin
               word_r <= bus.prog_q;
               state  <= DECODE;
            end
            DECODE: begin
               rep_cnt <= word_r[REP_MSB:REP_LSB];
               cmd_r   <= word_r[OP_MSB:0];
               end_r   <= word_r[END_B];
               if (is_terminator(word_r)) begin
                  state    <= FINISH;
                  seq_busy <= 1'b0;
                  seq_done <= 1'b1;
               end else begin
                  state <= WAIT_RDY;
               end
            end
            WAIT_RDY: begin
               if (!bus.lcd_busy) begin
                  state       <= ISSUE;
                  cmd_valid_r <= 1'b1;
               end else if (wd_exp) begin
                  state    <= FINISH;
                  seq_busy <= 1'b0;
                  seq_done <= 1'b1;
                  err      <= 1'b1;
               end
            end
            ISSUE: begin
               cmd_valid_r <= 1'b0;
               if (issued_cnt != ISSUED_MAX) begin
                  issued_cnt <= issued_cnt + CNT_W'(1);
               end
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (bus.lcd_busy) begin
                  wr_mode <= (cmd_r == OP_WRITE);
                  state   <= WAIT_CMPL;
               end else if (wd_exp) begin
                  state    <= FINISH;
                  seq_busy <= 1'b0;
                  seq_done <= 1'b1;
                  err      <= 1'b1;
               end
            end
            WAIT_CMPL: begin
               // a write ends the program; its repeat and later words are dropped
               if (wr_mode) begin
                  if (bus.lcd_done) begin
                     state    <= FINISH;
                     seq_busy <= 1'b0;
                     seq_done <= 1'b1;
                  end else if (wd_exp) begin
                     state    <= FINISH;
                     seq_busy <= 1'b0;
                     seq_done <= 1'b1;
                     err      <= 1'b1;
                  end
               end else if (!bus.lcd_busy) begin
                  if (rep_cnt != 4'd0) begin
                     rep_cnt     <= rep_cnt - 4'd1;
                     cmd_valid_r <= 1'b1;
                     state       <= ISSUE;
                  end else if (end_r) begin
                     state    <= FINISH;
                     seq_busy <= 1'b0;
                     seq_done <= 1'b1;
                  end else if (prog_a_r == PA_LAST) begin
                     state    <= FINISH;
                     seq_busy <= 1'b0;
                     seq_done <= 1'b1;
                     err      <= 1'b1;
                  end else begin
                     prog_a_r  <= prog_a_r + PROG_AW'(1);
                     prog_en_r <= 1'b1;
                     state     <= FETCH;
                  end
               end else if (wd_exp) begin
                  state    <= FINISH;
                  seq_busy <= 1'b0;
                  seq_done <= 1'b1;
                  err      <= 1'b1;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
